wbck_arb: RTL and testbench

WBCK_ARB -- requirements
Module: wbck_arb

---
 rtl/wbck_arb.sv | 121 ++++++++++++
 tb/tb_wbck_arb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wbck_arb.sv
// Write-back arbiter: merges the ALU, LSU and MULDIV result channels into a
// single registered regfile write port. Fixed priority muldiv > lsu > alu,
// with a starvation counter that promotes the ALU to top priority.
module wbck_arb #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned RFIDX_W    = 5,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               alu2wb_vld,
    output logic               alu2wb_rdy,
    input  logic [XLEN-1:0]    alu2wb_data,
    input  logic [RFIDX_W-1:0] alu2wb_rdidx,
    input  logic               alu2wb_rden,

    input  logic               lsu2wb_vld,
    output logic               lsu2wb_rdy,
    input  logic [XLEN-1:0]    lsu2wb_data,
    input  logic [RFIDX_W-1:0] lsu2wb_rdidx,
    input  logic               lsu2wb_rden,

    input  logic               muldiv2wb_vld,
    output logic               muldiv2wb_rdy,
    input  logic [XLEN-1:0]    muldiv2wb_data,
    input  logic [RFIDX_W-1:0] muldiv2wb_rdidx,
    input  logic               muldiv2wb_rden,

    output logic               wbck_o_vld,
    input  logic               wbck_o_rdy,
    output logic [XLEN-1:0]    wbck_o_data,
    output logic [RFIDX_W-1:0] wbck_o_rdidx,
    output logic               wbck_o_en,

    output logic               wbck_busy
);

    logic               can_load;
    logic               boost;
    logic [3:0]         cnt;
    logic               gnt_alu;
    logic               gnt_lsu;
    logic               gnt_mdv;
    logic               hs_alu;
    logic               hs_any;
    logic               hs_other;
    logic [XLEN-1:0]    sel_data;
    logic [RFIDX_W-1:0] sel_rdidx;
    logic               sel_rden;

    assign can_load = ~wbck_o_vld | wbck_o_rdy;
    assign boost    = (cnt == 4'(STARVE_MAX));

    // Pick at most one source; boost lifts the ALU above everything else
    always_comb begin
        gnt_alu = 1'b0;
        gnt_lsu = 1'b0;
        gnt_mdv = 1'b0;
        if (boost && alu2wb_vld)  gnt_alu = 1'b1;
        else if (muldiv2wb_vld)   gnt_mdv = 1'b1;
        else if (lsu2wb_vld)      gnt_lsu = 1'b1;
        else if (alu2wb_vld)      gnt_alu = 1'b1;
    end

    // rdy is masked during reset so no source believes a transfer happened
    assign alu2wb_rdy    = gnt_alu & can_load & ~rst;
    assign lsu2wb_rdy    = gnt_lsu & can_load & ~rst;
    assign muldiv2wb_rdy = gnt_mdv & can_load & ~rst;

    assign hs_alu   = alu2wb_vld & alu2wb_rdy;
    assign hs_other = (lsu2wb_vld & lsu2wb_rdy) | (muldiv2wb_vld & muldiv2wb_rdy);
    assign hs_any   = hs_alu | hs_other;

    // Route the granted source's payload toward the output buffer
    always_comb begin
        sel_data  = alu2wb_data;
        sel_rdidx = alu2wb_rdidx;
        sel_rden  = alu2wb_rden;
        if (gnt_mdv) begin
            sel_data  = muldiv2wb_data;
            sel_rdidx = muldiv2wb_rdidx;
            sel_rden  = muldiv2wb_rden;
        end else if (gnt_lsu) begin
            sel_data  = lsu2wb_data;
            sel_rdidx = lsu2wb_rdidx;
            sel_rden  = lsu2wb_rden;
        end
    end

    // Count cycles the ALU waits while another source is served
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!alu2wb_vld || hs_alu) begin
            cnt <= '0;
        end else if (hs_other && (cnt != 4'(STARVE_MAX))) begin
            cnt <= cnt + 4'd1;
        end
    end

    // Single-entry output buffer: load on handshake, else clear on drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbck_o_vld   <= 1'b0;
            wbck_o_en    <= 1'b0;
            wbck_o_data  <= '0;
            wbck_o_rdidx <= '0;
        end else if (hs_any) begin
            wbck_o_vld   <= 1'b1;
            wbck_o_en    <= sel_rden & (sel_rdidx != '0);
            wbck_o_data  <= sel_data;
            wbck_o_rdidx <= sel_rdidx;
        end else if (wbck_o_vld && wbck_o_rdy) begin
            wbck_o_vld   <= 1'b0;
        end
    end

    assign wbck_busy = wbck_o_vld | alu2wb_vld | lsu2wb_vld | muldiv2wb_vld;

endmodule

// File: tb/tb_wbck_arb.sv
// Directed bench for wbck_arb: inputs change on the falling edge, combinational
// outputs are checked 1ns later, registered outputs 1ns after the rising edge.
module tb_wbck_arb;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned RFIDX_W = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               alu2wb_vld,    alu2wb_rdy,    alu2wb_rden;
    logic [XLEN-1:0]    alu2wb_data;
    logic [RFIDX_W-1:0] alu2wb_rdidx;
    logic               lsu2wb_vld,    lsu2wb_rdy,    lsu2wb_rden;
    logic [XLEN-1:0]    lsu2wb_data;
    logic [RFIDX_W-1:0] lsu2wb_rdidx;
    logic               muldiv2wb_vld, muldiv2wb_rdy, muldiv2wb_rden;
    logic [XLEN-1:0]    muldiv2wb_data;
    logic [RFIDX_W-1:0] muldiv2wb_rdidx;
    logic               wbck_o_vld, wbck_o_rdy, wbck_o_en, wbck_busy;
    logic [XLEN-1:0]    wbck_o_data;
    logic [RFIDX_W-1:0] wbck_o_rdidx;

    int n_cmp = 0;
    int n_err = 0;

    wbck_arb #(.XLEN(XLEN), .RFIDX_W(RFIDX_W), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .alu2wb_vld(alu2wb_vld), .alu2wb_rdy(alu2wb_rdy), .alu2wb_data(alu2wb_data),
        .alu2wb_rdidx(alu2wb_rdidx), .alu2wb_rden(alu2wb_rden),
        .lsu2wb_vld(lsu2wb_vld), .lsu2wb_rdy(lsu2wb_rdy), .lsu2wb_data(lsu2wb_data),
        .lsu2wb_rdidx(lsu2wb_rdidx), .lsu2wb_rden(lsu2wb_rden),
        .muldiv2wb_vld(muldiv2wb_vld), .muldiv2wb_rdy(muldiv2wb_rdy), .muldiv2wb_data(muldiv2wb_data),
        .muldiv2wb_rdidx(muldiv2wb_rdidx), .muldiv2wb_rden(muldiv2wb_rden),
        .wbck_o_vld(wbck_o_vld), .wbck_o_rdy(wbck_o_rdy), .wbck_o_data(wbck_o_data),
        .wbck_o_rdidx(wbck_o_rdidx), .wbck_o_en(wbck_o_en), .wbck_busy(wbck_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rdys(input string tag, input logic a, input logic l, input logic m);
        chk({tag, ".alu_rdy"}, 64'(alu2wb_rdy), 64'(a));
        chk({tag, ".lsu_rdy"}, 64'(lsu2wb_rdy), 64'(l));
        chk({tag, ".mdv_rdy"}, 64'(muldiv2wb_rdy), 64'(m));
    endtask

    task automatic outp(input string tag, input logic v, input logic e,
                        input logic [RFIDX_W-1:0] idx, input logic [XLEN-1:0] d);
        chk({tag, ".vld"},   64'(wbck_o_vld),   64'(v));
        chk({tag, ".en"},    64'(wbck_o_en),    64'(e));
        chk({tag, ".rdidx"}, 64'(wbck_o_rdidx), 64'(idx));
        chk({tag, ".data"},  64'(wbck_o_data),  64'(d));
    endtask

    task automatic rise();
        @(posedge clk);
        #1;
    endtask

    task automatic fall();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        alu2wb_vld = 0; alu2wb_data = '0; alu2wb_rdidx = '0; alu2wb_rden = 0;
        lsu2wb_vld = 0; lsu2wb_data = '0; lsu2wb_rdidx = '0; lsu2wb_rden = 0;
        muldiv2wb_vld = 0; muldiv2wb_data = '0; muldiv2wb_rdidx = '0; muldiv2wb_rden = 0;
        wbck_o_rdy = 1'b0;

        // reset state
        #2;
        outp("rst", 0, 0, 0, 0);
        chk("rst.cnt", 64'(dut.cnt), 0);
        chk("rst.busy", 64'(wbck_busy), 0);
        alu2wb_vld = 1'b1;
        #1;
        rdys("rst_gate", 0, 0, 0);
        chk("rst.busy_alu", 64'(wbck_busy), 1);
        rise();
        outp("rst_hold", 0, 0, 0, 0);
        alu2wb_vld = 1'b0;
        fall();
        rst = 1'b0;

        // ALU only
        fall();
        alu2wb_vld = 1; alu2wb_data = 32'h1234; alu2wb_rdidx = 5; alu2wb_rden = 1;
        wbck_o_rdy = 1;
        #1;
        rdys("alu_req", 1, 0, 0);
        rise();
        outp("alu_out", 1, 1, 5, 32'h1234);
        fall();
        alu2wb_vld = 0;
        rise();
        outp("alu_drain", 0, 1, 5, 32'h1234);

        // all three valid -> muldiv, lsu, alu back-to-back
        fall();
        muldiv2wb_vld = 1; muldiv2wb_data = 32'hA1; muldiv2wb_rdidx = 1; muldiv2wb_rden = 1;
        lsu2wb_vld = 1;    lsu2wb_data = 32'hB2;    lsu2wb_rdidx = 2;    lsu2wb_rden = 1;
        alu2wb_vld = 1;    alu2wb_data = 32'hC3;    alu2wb_rdidx = 3;    alu2wb_rden = 1;
        #1;
        rdys("all_1", 0, 0, 1);
        rise();
        outp("all_mdv", 1, 1, 1, 32'hA1);
        fall();
        muldiv2wb_vld = 0;
        #1;
        rdys("all_2", 0, 1, 0);
        rise();
        outp("all_lsu", 1, 1, 2, 32'hB2);
        fall();
        lsu2wb_vld = 0;
        #1;
        rdys("all_3", 1, 0, 0);
        rise();
        outp("all_alu", 1, 1, 3, 32'hC3);
        chk("all.cnt", 64'(dut.cnt), 0);
        fall();
        alu2wb_vld = 0;
        rise();
        chk("all_drain.vld", 64'(wbck_o_vld), 0);

        // starvation: lsu wins 4 times, then boosted alu
        fall();
        alu2wb_vld = 1; alu2wb_data = 32'hAA; alu2wb_rdidx = 7; alu2wb_rden = 1;
        lsu2wb_vld = 1; lsu2wb_rdidx = 4; lsu2wb_rden = 1;
        for (int i = 0; i < 4; i++) begin
            lsu2wb_data = 32'h100 + 32'(i);
            #1;
            rdys($sformatf("stv_%0d", i), 0, 1, 0);
            rise();
            outp($sformatf("stv_out%0d", i), 1, 1, 4, 32'h100 + 32'(i));
            chk($sformatf("stv_cnt%0d", i), 64'(dut.cnt), 64'(i + 1));
            fall();
        end
        lsu2wb_data = 32'h200;
        #1;
        rdys("stv_boost", 1, 0, 0);
        rise();
        outp("stv_alu", 1, 1, 7, 32'hAA);
        chk("stv_cnt_clr", 64'(dut.cnt), 0);
        fall();
        alu2wb_vld = 0;
        #1;
        rdys("stv_after", 0, 1, 0);
        rise();
        outp("stv_lsu", 1, 1, 4, 32'h200);
        fall();
        lsu2wb_vld = 0;
        rise();

        // backpressure: hold full buffer 3 cycles, then drain + reload
        fall();
        wbck_o_rdy = 0;
        muldiv2wb_vld = 1; muldiv2wb_data = 32'h55; muldiv2wb_rdidx = 9; muldiv2wb_rden = 1;
        #1;
        rdys("bp_load", 0, 0, 1);
        rise();
        outp("bp_full", 1, 1, 9, 32'h55);
        fall();
        muldiv2wb_data = 32'h66; muldiv2wb_rdidx = 10;
        lsu2wb_vld = 1; alu2wb_vld = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            rdys($sformatf("bp_stall%0d", i), 0, 0, 0);
            rise();
            outp($sformatf("bp_hold%0d", i), 1, 1, 9, 32'h55);
            fall();
        end
        wbck_o_rdy = 1;
        #1;
        rdys("bp_release", 0, 0, 1);
        rise();
        outp("bp_reload", 1, 1, 10, 32'h66);
        chk("bp.cnt", 64'(dut.cnt), 1);
        fall();
        muldiv2wb_vld = 0; lsu2wb_vld = 0; alu2wb_vld = 0;
        rise();
        chk("bp_drain.vld", 64'(wbck_o_vld), 0);

        // rdidx = 0 and rden = 0 still accepted, with en = 0
        fall();
        alu2wb_vld = 1; alu2wb_data = 32'h77; alu2wb_rdidx = 0; alu2wb_rden = 1;
        #1;
        rdys("x0_req", 1, 0, 0);
        rise();
        outp("x0_out", 1, 0, 0, 32'h77);
        fall();
        alu2wb_data = 32'h88; alu2wb_rdidx = 4; alu2wb_rden = 0;
        rise();
        outp("noren_out", 1, 0, 4, 32'h88);
        fall();
        alu2wb_vld = 0;
        rise();

        // reset pulse while the buffer holds data
        fall();
        lsu2wb_vld = 1; lsu2wb_data = 32'h99; lsu2wb_rdidx = 6; lsu2wb_rden = 1;
        alu2wb_vld = 1; alu2wb_data = 32'hBB; alu2wb_rdidx = 8; alu2wb_rden = 1;
        rise();
        outp("mr_pre", 1, 1, 6, 32'h99);
        chk("mr_pre.cnt", 64'(dut.cnt), 1);
        fall();
        lsu2wb_data = 32'h9A;
        #2;
        rst = 1;
        #1;
        outp("mr_async", 0, 0, 0, 0);
        chk("mr_async.cnt", 64'(dut.cnt), 0);
        rdys("mr_gate", 0, 0, 0);
        rise();
        outp("mr_edge", 0, 0, 0, 0);
        fall();
        rst = 0;
        #1;
        rdys("mr_first", 0, 1, 0);
        rise();
        outp("mr_grant", 1, 1, 6, 32'h9A);
        fall();
        lsu2wb_vld = 0; alu2wb_vld = 0;
        rise();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
